// File: rtl/pill_feeder.sv
// Pill feeder sequencer: emits pill-drop pulses at a programmable period,
// pauses for a settle window while bottles are swapped, waits for permission
// to continue, and stops once every bottle is full. Pills emitted since the
// last idle period are counted in two BCD digits.
module pill_feeder #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN_work,
  input  logic       conti,
  input  logic       bot_full,
  input  logic       allFull,
  input  logic [3:0] rate,
  output logic       pill,
  output logic       feeding,
  output logic       swap,
  output logic       done,
  output logic [3:0] fed_H,
  output logic [3:0] fed_L
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FEED = 3'd1,
    SWAP = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] gap, gap_nxt;
  logic [3:0] settle, settle_nxt;
  logic       pill_nxt;
  logic [3:0] fed_H_nxt, fed_L_nxt;
  logic [3:0] gap_last;
  logic [3:0] inc_H, inc_L;

  // Gap count at which the next pill is due: R-1, with rate 0 behaving as 1.
  always_comb begin
    gap_last = (rate == '0) ? '0 : rate - 4'd1;
  end

  // Two-digit BCD successor of the pill count, wrapping 99 to 00.
  always_comb begin
    inc_H = fed_H;
    inc_L = fed_L + 4'd1;
    if (fed_L >= 4'd9) begin
      inc_L = '0;
      inc_H = (fed_H >= 4'd9) ? '0 : fed_H + 4'd1;
    end
  end

  // Next-state, gap/settle counters, pill strobe and count update.
  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap;
    settle_nxt = settle;
    pill_nxt   = 1'b0;
    fed_H_nxt  = fed_H;
    fed_L_nxt  = fed_L;

    if (!EN_work) begin
      state_nxt  = IDLE;
      gap_nxt    = '0;
      settle_nxt = '0;
      fed_H_nxt  = '0;
      fed_L_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt  = FEED;
          gap_nxt    = '0;
          settle_nxt = '0;
          fed_H_nxt  = '0;
          fed_L_nxt  = '0;
        end
        FEED: begin
          if (allFull) begin
            state_nxt = DONE;
            gap_nxt   = '0;
          end else if (bot_full) begin
            state_nxt  = SWAP;
            gap_nxt    = '0;
            settle_nxt = '0;
          end else if (gap >= gap_last) begin
            // Comparing with >= lets a shortened rate fire immediately.
            pill_nxt  = 1'b1;
            gap_nxt   = '0;
            fed_H_nxt = inc_H;
            fed_L_nxt = inc_L;
          end else begin
            gap_nxt = gap + 4'd1;
          end
        end
        SWAP: begin
          if (allFull) begin
            state_nxt = DONE;
          end else if (settle == SETTLE_LAST) begin
            state_nxt  = conti ? FEED : HOLD;
            gap_nxt    = '0;
            settle_nxt = '0;
          end else begin
            settle_nxt = settle + 4'd1;
          end
        end
        HOLD: begin
          if (allFull) begin
            state_nxt = DONE;
          end else if (conti && !bot_full) begin
            state_nxt = FEED;
            gap_nxt   = '0;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= IDLE;
      gap    <= '0;
      settle <= '0;
      pill   <= 1'b0;
      fed_H  <= '0;
      fed_L  <= '0;
    end else begin
      state  <= state_nxt;
      gap    <= gap_nxt;
      settle <= settle_nxt;
      pill   <= pill_nxt;
      fed_H  <= fed_H_nxt;
      fed_L  <= fed_L_nxt;
    end
  end

  // Status flags decoded from the registered state.
  always_comb begin
    feeding = (state == FEED);
    swap    = (state == SWAP) || (state == HOLD);
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_pill_feeder.sv
// Self-checking bench for pill_feeder: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the feeder rules.
module tb_pill_feeder;

  localparam int unsigned SETTLE = 4;

  localparam int M_IDLE = 0;
  localparam int M_FEED = 1;
  localparam int M_SWAP = 2;
  localparam int M_HOLD = 3;
  localparam int M_DONE = 4;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       EN_work;
  logic       conti;
  logic       bot_full;
  logic       allFull;
  logic [3:0] rate;
  logic       pill;
  logic       feeding;
  logic       swap;
  logic       done;
  logic [3:0] fed_H;
  logic [3:0] fed_L;
  logic [11:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mode, edges elapsed since last pill/entry, settle edges,
  // total pills mod 100, and the pill strobe produced on the last edge.
  int m_st  = M_IDLE;
  int m_el  = 0;
  int m_set = 0;
  int m_cnt = 0;
  bit m_pill = 1'b0;

  pill_feeder #(.SETTLE(SETTLE)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN_work(EN_work), .conti(conti),
    .bot_full(bot_full), .allFull(allFull), .rate(rate),
    .pill(pill), .feeding(feeding), .swap(swap), .done(done),
    .fed_H(fed_H), .fed_L(fed_L)
  );

  always #5 CLK = ~CLK;

  assign obs = {pill, feeding, swap, done, fed_H, fed_L};

  function automatic logic [11:0] exp_vec();
    logic [3:0] h, l;
    h = 4'(m_cnt / 10);
    l = 4'(m_cnt % 10);
    return {m_pill, (m_st == M_FEED), (m_st == M_SWAP || m_st == M_HOLD),
            (m_st == M_DONE), h, l};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_el = 0; m_set = 0; m_cnt = 0; m_pill = 1'b0;
  endtask

  task automatic model_edge();
    int r;
    m_pill = 1'b0;
    r = (rate == 4'd0) ? 1 : int'(rate);
    if (!RST_n) begin
      model_reset();
    end else if (m_st == M_IDLE) begin
      if (EN_work) begin m_st = M_FEED; m_el = 0; m_cnt = 0; end
    end else if (!EN_work) begin
      m_st = M_IDLE; m_cnt = 0;
    end else if (m_st != M_DONE && allFull) begin
      m_st = M_DONE;
    end else if (m_st == M_FEED) begin
      if (bot_full) begin
        m_st = M_SWAP; m_set = 0; m_el = 0;
      end else begin
        m_el = m_el + 1;
        if (m_el >= r) begin
          m_pill = 1'b1; m_el = 0; m_cnt = (m_cnt + 1) % 100;
        end
      end
    end else if (m_st == M_SWAP) begin
      m_set = m_set + 1;
      if (m_set == int'(SETTLE)) begin
        m_st = conti ? M_FEED : M_HOLD; m_el = 0; m_set = 0;
      end
    end else if (m_st == M_HOLD) begin
      if (conti && !bot_full) begin m_st = M_FEED; m_el = 0; end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic go_idle();
    @(negedge CLK);
    EN_work = 1'b0; bot_full = 1'b0; allFull = 1'b0; conti = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++; $display("FAIL reset_async: got %h want %h", obs, 12'h000);
    end
    EN_work = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL reset_held: got %h want %h", obs, exp_vec());
      end
    end
    @(negedge CLK);
    RST_n = 1'b1; EN_work = 1'b0;
    step();
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++; $display("FAIL reset_idle: got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_rate3();
    go_idle();
    @(negedge CLK);
    rate = 4'd3; EN_work = 1'b1;
    step();
    vectors++;
    if (feeding !== 1'b1 || pill !== 1'b0) begin
      miscompares++; $display("FAIL rate3_entry: got f=%b p=%b want f=1 p=0", feeding, pill);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL rate3_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
      vectors++;
      if (pill !== (k % 3 == 0) || fed_L !== 4'(k / 3)) begin
        miscompares++;
        $display("FAIL rate3_pill k=%0d: got p=%b L=%0d want p=%b L=%0d",
                 k, pill, fed_L, (k % 3 == 0), k / 3);
      end
    end
  endtask

  task automatic test_wrap();
    go_idle();
    @(negedge CLK);
    rate = 4'd0; EN_work = 1'b1;
    step();
    for (int k = 1; k <= 100; k++) begin
      if (k == 11) begin
        @(negedge CLK);
        rate = 4'd1;
      end
      step();
      vectors++;
      if (obs !== exp_vec() || pill !== 1'b1) begin
        miscompares++; $display("FAIL wrap_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
      if (k == 99) begin
        vectors++;
        if ({fed_H, fed_L} !== 8'h99) begin
          miscompares++; $display("FAIL wrap_99: got %h%h want 99", fed_H, fed_L);
        end
      end
      if (k == 100) begin
        vectors++;
        if ({fed_H, fed_L} !== 8'h00) begin
          miscompares++; $display("FAIL wrap_00: got %h%h want 00", fed_H, fed_L);
        end
      end
    end
  endtask

  task automatic test_swap_conti();
    go_idle();
    @(negedge CLK);
    rate = 4'd2; EN_work = 1'b1; conti = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      bot_full = (k == 4);
      step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL swap_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
      vectors++;
      if (swap !== (k >= 4 && k <= 7) || pill !== (k == 2 || k == 10) ||
          feeding !== (k < 4 || k > 7)) begin
        miscompares++;
        $display("FAIL swap_seq k=%0d: got s=%b p=%b f=%b", k, swap, pill, feeding);
      end
    end
  endtask

  task automatic test_hold();
    go_idle();
    @(negedge CLK);
    rate = 4'd2; EN_work = 1'b1; conti = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      bot_full = (k == 4) || (k == 13) || (k == 14);
      conti = (k >= 13);
      step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL hold_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
      vectors++;
      if (swap !== (k >= 4 && k <= 14) || feeding !== (k < 4 || k > 14)) begin
        miscompares++;
        $display("FAIL hold_seq k=%0d: got s=%b f=%b", k, swap, feeding);
      end
    end
  endtask

  task automatic test_done();
    go_idle();
    @(negedge CLK);
    rate = 4'd1; EN_work = 1'b1; conti = 1'b1;
    step(); step(); step();
    @(negedge CLK);
    allFull = 1'b1; bot_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (obs !== exp_vec() || done !== 1'b1 || pill !== 1'b0 || swap !== 1'b0) begin
        miscompares++; $display("FAIL done_hold k=%0d: got %h want %h", k, obs, exp_vec());
      end
    end
    @(negedge CLK);
    EN_work = 1'b0; allFull = 1'b0; bot_full = 1'b0;
    step();
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++; $display("FAIL done_exit: got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    @(negedge CLK);
    rate = 4'd1; EN_work = 1'b1;
    step(); step();
    vectors++;
    if (pill !== 1'b1) begin
      miscompares++; $display("FAIL arst_pre: got p=%b want 1", pill);
    end
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++; $display("FAIL arst_clear: got %h want %h", obs, 12'h000);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    step();
    vectors++;
    if (obs !== exp_vec() || feeding !== 1'b1 || pill !== 1'b0) begin
      miscompares++; $display("FAIL arst_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      RST_n    = ($urandom_range(0, 199) != 0);
      EN_work  = ($urandom_range(0, 24) != 0);
      bot_full = ($urandom_range(0, 11) == 0);
      allFull  = ($urandom_range(0, 79) == 0);
      conti    = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0) rate = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) rate = 4'($urandom_range(0, 4));
      step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL random i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  initial begin
    RST_n = 1'b1; EN_work = 1'b0; conti = 1'b0; bot_full = 1'b0;
    allFull = 1'b0; rate = 4'd0;
    #1;
    RST_n = 1'b0;
    model_reset();
    test_reset();
    test_rate3();
    test_wrap();
    test_swap_conti();
    test_hold();
    test_done();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pill_feeder.md
PILL_FEEDER -- requirements
Module: pill_feeder

Interface
REQ-001 Parameter SETTLE, default 4, range 1-15: clock edges spent in bottle-swap before feeding may resume.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_n  input  1  asynchronous active-low reset.
REQ-004 EN_work  input  1  work enable; level-sensitive; 0 forces IDLE.
REQ-005 conti  input  1  continue permission after bottle swap; level-sensitive.
REQ-006 bot_full  input  1  current bottle reached its pill maximum; from the bottling counter.
REQ-007 allFull  input  1  all bottles filled; from the bottling counter.
REQ-008 rate  input  4  unsigned pill period in clock edges; 0 treated as 1.
REQ-009 pill  output  1  registered one-cycle pill-drop pulse to the bottling counter.
REQ-010 feeding  output  1  high while state is FEED.
REQ-011 swap  output  1  high while state is SWAP or HOLD.
REQ-012 done  output  1  high while state is DONE.
REQ-013 fed_H, fed_L  output  4 each  BCD tens/ones of pills emitted since leaving IDLE.

Function
REQ-014 States: IDLE, FEED, SWAP, HOLD, DONE; all outputs registered or decoded from registered state only.
REQ-015 Transition priority, highest first: RST_n low, EN_work low, allFull high, bot_full high, normal progression.
REQ-016 Any state with EN_work=0 -> IDLE on next edge; pill=0 on that edge.
REQ-017 IDLE -> FEED on the edge where EN_work=1; gap counter cleared to 0; fed_H:fed_L cleared to 00 on entry to IDLE and held at 00 throughout IDLE.
REQ-018 FEED, R = max(rate,1): pill asserted on the R-th edge after FEED entry and every R edges thereafter; exactly one cycle high each time; rate=1 gives pill high every cycle.
REQ-019 rate sampled every cycle; a change takes effect at the next gap-counter compare; if gap counter already >= new R-1, pill fires on the next edge.
REQ-020 FEED with bot_full=1 -> SWAP; no pill on that edge; gap counter cleared; SETTLE counter cleared.
REQ-021 SWAP counts SETTLE edges; on the SETTLE-th edge: conti=1 -> FEED (gap counter 0), conti=0 -> HOLD.
REQ-022 HOLD -> FEED on first edge with conti=1 and bot_full=0; stays in HOLD while bot_full=1.
REQ-023 FEED, SWAP or HOLD with allFull=1 -> DONE; pill=0 on that edge; DONE held until EN_work=0.
REQ-024 Each emitted pill increments fed_H:fed_L in BCD on the same edge pill rises; 09 -> 10; 99 -> 00 wrap; digits never exceed 9.
REQ-025 bot_full and allFull in the same cycle: allFull wins (DONE).
REQ-026 pill never asserted outside FEED and never on an edge leaving FEED.

Reset
REQ-027 RST_n low, asynchronous: state IDLE, pill=0, feeding=0, swap=0, done=0, fed_H=0, fed_L=0, gap and SETTLE counters 0.
REQ-028 Reset release: first state change no earlier than the first rising edge with RST_n high; reset mid-FEED truncates any pending pill, no partial pulse.

Verification
REQ-029 rate=3, EN_work rises, bot_full=0 -> pill high on edges 3, 6, 9 after FEED entry, each one cycle; fed_L counts 1,2,3.
REQ-030 rate=0 then rate=1 -> pill high every cycle in FEED; after 100 pills fed_H:fed_L = 00 (99 -> 00 wrap).
REQ-031 rate=2, bot_full pulsed on a pill-due edge, conti=1, SETTLE=4 -> no pill that edge, swap high 4 cycles, FEED resumes, next pill 2 edges later.
REQ-032 Same with conti=0 -> HOLD; conti raised 5 cycles later -> FEED next edge; bot_full held high blocks exit.
REQ-033 allFull and bot_full together in FEED -> DONE, done=1, pill=0; EN_work dropped -> IDLE, fed cleared to 00.
REQ-034 RST_n asserted mid-gap between edges -> all outputs 0 immediately without clock; release with EN_work=1 -> FEED entry on first subsequent edge.
